// File: rtl/vga_pattern_gen.sv
// VGA timing and test-pattern generator: 640x480@60 Hz from a 50 MHz clock with a 25 MHz pixel enable.
// Four switch-selected patterns drive the ADV7123 DAC; timing geometry is parameterised.
module vga_pattern_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] switch,
  output logic       vga_clk,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_blank_n,
  output logic       vga_sync_n,
  output logic [9:0] vga_r,
  output logic [9:0] vga_g,
  output logic [9:0] vga_b
);

  typedef enum logic [1:0] {
    PAT_BARS    = 2'b00,
    PAT_CHECKER = 2'b01,
    PAT_RAMP    = 2'b10,
    PAT_SQUARE  = 2'b11
  } pat_t;

  localparam int SQ_SIZE = 32;
  localparam int BAR_W   = H_ACTIVE / 8;

  localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] SQ_X_MAX = 10'(H_ACTIVE - SQ_SIZE);
  localparam logic [9:0] SQ_Y_MAX = 10'(V_ACTIVE - SQ_SIZE);
  localparam logic [9:0] SQ_X_RST = 10'((H_ACTIVE - SQ_SIZE) / 2);
  localparam logic [9:0] SQ_Y_RST = 10'((V_ACTIVE - SQ_SIZE) / 2);
  localparam logic [9:0] FULL     = 10'h3FF;

  logic       pix_en;
  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic [1:0] sw_meta;
  logic [1:0] sw_sync;
  pat_t       pat;
  logic [9:0] sq_x;
  logic [9:0] sq_y;
  logic       dx_pos;
  logic       dy_pos;

  logic       h_last;
  logic       v_last;
  logic       frame_end;
  logic       dx_next;
  logic       dy_next;
  logic       active;
  logic       in_sq;
  logic [2:0] bar;
  logic [9:0] r_next;
  logic [9:0] g_next;
  logic [9:0] b_next;

  assign h_last     = (h_cnt == H_LAST);
  assign v_last     = (v_cnt == V_LAST);
  assign frame_end  = pix_en && h_last && v_last;
  assign vga_sync_n = 1'b0;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pix_en  <= 1'b0;
      vga_clk <= 1'b0;
    end else begin
      pix_en  <= ~pix_en;
      vga_clk <= pix_en;
    end
  end

  // Two-flop synchroniser; runs every clock so its latency is independent of the pixel phase.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sw_meta <= 2'b00;
      sw_sync <= 2'b00;
    end else begin
      sw_meta <= switch;
      sw_sync <= sw_meta;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en) begin
      if (h_last) begin
        h_cnt <= '0;
        v_cnt <= v_last ? 10'd0 : v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end
  end

  // A direction flips when the square sits on either edge of its range, then the step is taken.
  always_comb begin
    dx_next = (sq_x == SQ_X_MAX || sq_x == 10'd0) ? ~dx_pos : dx_pos;
    dy_next = (sq_y == SQ_Y_MAX || sq_y == 10'd0) ? ~dy_pos : dy_pos;
  end

  // Pattern and square only change at the last pixel of a frame, so a frame is never torn.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pat    <= PAT_BARS;
      sq_x   <= SQ_X_RST;
      sq_y   <= SQ_Y_RST;
      dx_pos <= 1'b1;
      dy_pos <= 1'b1;
    end else if (frame_end) begin
      pat    <= pat_t'(sw_sync);
      dx_pos <= dx_next;
      dy_pos <= dy_next;
      sq_x   <= dx_next ? sq_x + 10'd1 : sq_x - 10'd1;
      sq_y   <= dy_next ? sq_y + 10'd1 : sq_y - 10'd1;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    r_next = '0;
    g_next = '0;
    b_next = '0;
    bar    = '0;
    active = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    in_sq  = (h_cnt >= sq_x) && (11'(h_cnt) < 11'(sq_x) + 11'(SQ_SIZE)) &&
             (v_cnt >= sq_y) && (11'(v_cnt) < 11'(sq_y) + 11'(SQ_SIZE));

    for (int k = 1; k < 8; k++) begin
      if (h_cnt >= 10'(k * BAR_W)) bar = 3'(k);
    end

    unique case (pat)
      // Bar index bits map straight onto inverted colour components.
      PAT_BARS: begin
        r_next = {10{~bar[1]}};
        g_next = {10{~bar[2]}};
        b_next = {10{~bar[0]}};
      end
      PAT_CHECKER: begin
        r_next = {10{h_cnt[5] ^ v_cnt[5]}};
        g_next = {10{h_cnt[5] ^ v_cnt[5]}};
        b_next = {10{h_cnt[5] ^ v_cnt[5]}};
      end
      PAT_RAMP: begin
        r_next = h_cnt;
        g_next = h_cnt;
        b_next = h_cnt;
      end
      PAT_SQUARE: begin
        r_next = in_sq ? FULL : 10'd0;
        g_next = in_sq ? FULL : 10'd0;
        b_next = FULL;
      end
      default: ;
    endcase

    if (!active) begin
      r_next = '0;
      g_next = '0;
      b_next = '0;
    end
  end

  // Sync and colour share one register stage so they stay pixel-aligned.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_blank_n <= 1'b0;
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
    end else if (pix_en) begin
      vga_hs      <= !((h_cnt >= HS_START) && (h_cnt < HS_END));
      vga_vs      <= !((v_cnt >= VS_START) && (v_cnt < VS_END));
      vga_blank_n <= active;
      vga_r       <= r_next;
      vga_g       <= g_next;
      vga_b       <= b_next;
    end
  end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Scoreboard bench for vga_pattern_gen on a shrunken 40x34 raster (56x37 total) to keep frames short.
// Expected pixels are queued by stimulus; a monitor tracks raster position and compares on each pixel.
module tb_vga_pattern_gen;

  localparam int H_ACTIVE = 40, H_FP = 4, H_SYNC = 8, H_BP = 4;
  localparam int V_ACTIVE = 34, V_FP = 1, V_SYNC = 1, V_BP = 1;
  localparam int H_TOT = 56;
  localparam int V_TOT = 37;
  localparam int F_PIX = H_TOT * V_TOT;
  localparam logic [9:0] FS = 10'h3FF;
  localparam logic [9:0] Z  = 10'h000;

  logic       clock   = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] switch  = 2'b00;
  logic       vga_clk, vga_hs, vga_vs, vga_blank_n, vga_sync_n;
  logic [9:0] vga_r, vga_g, vga_b;

  always #10 clock = ~clock;

  vga_pattern_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) dut (
    .clock(clock), .reset_n(reset_n), .switch(switch),
    .vga_clk(vga_clk), .vga_hs(vga_hs), .vga_vs(vga_vs),
    .vga_blank_n(vga_blank_n), .vga_sync_n(vga_sync_n),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
  );

  typedef struct {
    int          idx;
    string       name;
    logic [32:0] val;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   mon_h = 0, mon_v = 0, mon_frame = 0;
  int   cur;
  exp_t e;
  bit   timing_done = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  function automatic logic [32:0] pix(input logic hs, input logic vs, input logic bl,
                                      input logic [9:0] r, input logic [9:0] g, input logic [9:0] b);
    return {hs, vs, bl, r, g, b};
  endfunction

  function automatic logic [32:0] act(input logic [9:0] r, input logic [9:0] g, input logic [9:0] b);
    return {1'b1, 1'b1, 1'b1, r, g, b};
  endfunction

  // Sorted insert so expectations may be queued in any order.
  task automatic push(input string name, input int f, input int h, input int v, input logic [32:0] val);
    exp_t n;
    int   pos;
    n.idx  = f * F_PIX + v * H_TOT + h;
    n.name = name;
    n.val  = val;
    pos = sb.size();
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].idx > n.idx) begin
        pos = i;
        break;
      end
    end
    sb.insert(pos, n);
  endtask

  // A new pixel is on the pins whenever vga_clk is high at the falling edge.
  always @(negedge clock) begin
    if (!reset_n) begin
      mon_h = 0; mon_v = 0; mon_frame = 0;
    end else if (vga_clk) begin
      cur = mon_frame * F_PIX + mon_v * H_TOT + mon_h;
      while (sb.size() > 0 && sb[0].idx <= cur) begin
        e = sb.pop_front();
        if (e.idx < cur) check({e.name, "_missed"}, 64'(cur), 64'(e.idx));
        else check(e.name, 64'({vga_hs, vga_vs, vga_blank_n, vga_r, vga_g, vga_b}), 64'(e.val));
      end
      mon_h++;
      if (mon_h == H_TOT) begin
        mon_h = 0;
        mon_v++;
        if (mon_v == V_TOT) begin
          mon_v = 0;
          mon_frame++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic sel(input int s);
    case (s)
      0:       return vga_hs;
      1:       return vga_vs;
      default: return vga_blank_n;
    endcase
  endfunction

  task automatic run_len(input int s, input logic lvl, input int budget, output int n);
    n = 0;
    while (sel(s) == lvl && n < budget) begin
      tick();
      n++;
    end
  endtask

  // Sync-timing measurements in clocks after the first reset release.
  initial begin
    int n, lo, hi;
    @(posedge reset_n);
    run_len(0, 1'b1, 2000, n);
    check("hs_first_fall", 64'(n), 64'(2 * (H_ACTIVE + H_FP) + 2));
    run_len(0, 1'b0, 2000, lo);
    run_len(0, 1'b1, 2000, hi);
    check("hs_low", 64'(lo), 64'(2 * H_SYNC));
    check("hs_period", 64'(lo + hi), 64'(2 * H_TOT));
    run_len(2, 1'b0, 2000, n);
    run_len(2, 1'b1, 2000, hi);
    check("blank_high", 64'(hi), 64'(2 * H_ACTIVE));
    run_len(1, 1'b1, 10000, n);
    run_len(1, 1'b0, 10000, lo);
    run_len(1, 1'b1, 10000, hi);
    check("vs_low", 64'(lo), 64'(2 * V_SYNC * H_TOT));
    check("vs_period", 64'(lo + hi), 64'(2 * F_PIX));
    timing_done = 1'b1;
  end

  task automatic wait_pos(input int f, input int v, input int budget);
    int n = 0;
    while (!(mon_frame == f && mon_v == v) && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (n >= budget) check("wait_pos_timeout", 64'(0), 64'(1));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_hs"}, 64'(vga_hs), 64'(1));
    check({tag, "_vs"}, 64'(vga_vs), 64'(1));
    check({tag, "_blank"}, 64'(vga_blank_n), 64'(0));
    check({tag, "_sync_n"}, 64'(vga_sync_n), 64'(0));
    check({tag, "_clk"}, 64'(vga_clk), 64'(0));
    check({tag, "_rgb"}, 64'({vga_r, vga_g, vga_b}), 64'(0));
  endtask

  initial begin
    int n;
    repeat (5) @(posedge clock);
    #1;
    check_reset_outputs("rst");

    // Frame 0: colour bars (5 px each), sync and blanking edges.
    push("bar_white",   0,  0,  0, act(FS, FS, FS));
    push("blank_h40",   0, 40,  0, pix(1'b1, 1'b1, 1'b0, Z, Z, Z));
    push("hs_h43",      0, 43,  1, pix(1'b1, 1'b1, 1'b0, Z, Z, Z));
    push("hs_h44",      0, 44,  1, pix(1'b0, 1'b1, 1'b0, Z, Z, Z));
    push("hs_h51",      0, 51,  1, pix(1'b0, 1'b1, 1'b0, Z, Z, Z));
    push("hs_h52",      0, 52,  1, pix(1'b1, 1'b1, 1'b0, Z, Z, Z));
    push("bar_cyan",    0, 12,  3, act(Z, FS, FS));
    push("bar_magenta", 0, 22,  3, act(FS, Z, FS));
    push("bar_yellow",  0,  7, 10, act(FS, FS, Z));
    push("bar_black",   0, 37, 10, act(Z, Z, Z));
    push("last_active", 0, 39, 33, act(Z, Z, Z));
    push("vblank_v34",  0,  5, 34, pix(1'b1, 1'b1, 1'b0, Z, Z, Z));
    push("vs_v35",      0,  5, 35, pix(1'b1, 1'b0, 1'b0, Z, Z, Z));
    push("vs_v36",      0,  5, 36, pix(1'b1, 1'b1, 1'b0, Z, Z, Z));
    @(negedge clock);
    reset_n = 1'b1;

    wait_pos(0, 20, 3 * F_PIX * 2);
    switch = 2'b01;
    push("mid_bars",    0,  7, 25, act(FS, FS, Z));
    push("chk_00",      1,  0,  0, act(Z, Z, Z));
    push("chk_31_0",    1, 31,  0, act(Z, Z, Z));
    push("chk_32_0",    1, 32,  0, act(FS, FS, FS));
    push("chk_0_32",    1,  0, 32, act(FS, FS, FS));
    push("chk_32_32",   1, 32, 32, act(Z, Z, Z));

    wait_pos(1, 20, 3 * F_PIX * 2);
    switch = 2'b10;
    push("mid_chk",     1, 32, 25, act(FS, FS, FS));
    push("ramp_0",      2,  0,  0, act(Z, Z, Z));
    push("ramp_20",     2, 20,  5, act(10'd20, 10'd20, 10'd20));
    push("ramp_39",     2, 39,  5, act(10'd39, 10'd39, 10'd39));
    push("ramp_blank",  2, 45,  5, pix(1'b0, 1'b1, 1'b0, Z, Z, Z));

    wait_pos(2, 20, 3 * F_PIX * 2);
    switch = 2'b11;
    push("mid_ramp",    2, 20, 25, act(10'd20, 10'd20, 10'd20));
    // Square at (7,0), then (8,1) on its right bound, then back to (7,2).
    push("f3_left",     3,  6,  0, act(Z, Z, FS));
    push("f3_corner",   3,  7,  0, act(FS, FS, FS));
    push("f3_right",    3, 39,  0, act(Z, Z, FS));
    push("f3_far",      3, 38, 31, act(FS, FS, FS));
    push("f3_below",    3,  7, 32, act(Z, Z, FS));
    push("f4_above",    4,  8,  0, act(Z, Z, FS));
    push("f4_left",     4,  7,  1, act(Z, Z, FS));
    push("f4_corner",   4,  8,  1, act(FS, FS, FS));
    push("f5_left",     5,  6,  2, act(Z, Z, FS));
    push("f5_corner",   5,  7,  2, act(FS, FS, FS));
    push("f5_far",      5, 38, 33, act(FS, FS, FS));

    wait_pos(6, 20, 5 * F_PIX * 2);
    check("sb_drained", 64'(sb.size()), 64'(0));
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (5) @(posedge clock);
    @(negedge clock);
    push("rs_white",    0,  0,  0, act(FS, FS, FS));
    push("rs_yellow",   0,  7, 10, act(FS, FS, Z));
    push("rs_above",    1,  5,  1, act(Z, Z, FS));
    push("rs_left",     1,  4,  2, act(Z, Z, FS));
    push("rs_corner",   1,  5,  2, act(FS, FS, FS));
    push("rs_bottom",   1,  5, 33, act(FS, FS, FS));
    reset_n = 1'b1;

    n = 0;
    while (sb.size() > 0 && n < 3 * F_PIX * 2) begin
      @(negedge clock);
      n++;
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check({e.name, "_never_seen"}, 64'(0), 64'(1));
    end
    n = 0;
    while (!timing_done && n < 1000) begin
      @(negedge clock);
      n++;
    end
    if (!timing_done) check("timing_timeout", 64'(0), 64'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
